bsg_mux_buffered: RTL and testbench
===================================

// Module: bsg_mux_buffered
// PURPOSE
//  - Parametrised successor to the flat pass-through mux: selects one of els_p
//    width_p-bit elements and registers the result into a 2-entry output buffer.
//  - Valid/ready input and valid/yumi output give full throughput with backpressure.
//  - Sits between a multi-source datapath and a registered consumer; breaks the
//    comb mux + select path from downstream timing.
// PARAMETERS
//  - width_p   default 128  bits per element
//  - els_p     default 2    number of selectable elements; els_p >= 1
//  - lg_els_lp derived      els_p==1 ? 1 : $clog2(els_p); width of sel_i
// PORTS
//  - clk_i    in   1                  clock; all state updates on the rising edge
//  - reset_i  in   1                  reset, asynchronous, active-high
//  - v_i      in   1                  input valid
//  - data_i   in   els_p*width_p      element k is data_i[k*width_p +: width_p]
//  - sel_i    in   lg_els_lp          binary select, sampled with v_i
//  - ready_o  out  1                  buffer can accept; registered
//  - v_o      out  1                  head entry valid
//  - data_o   out  width_p            head entry data
//  - yumi_i   in   1                  consumer takes head; legal only when v_o=1
//  - err_o    out  1                  sticky select error, see CONFIGURATION
// BEHAVIOUR
//  - Accept: v_i & ready_o. On accept, the selected element is written to the tail entry.
//  - Dequeue: yumi_i. This pops the head entry.
//  - count in {0,1,2}. ready_o = (count<2); v_o = (count!=0). Both derive only
//    from registered state, with no comb path from v_i/yumi_i.
//  - Latency: data accepted in cycle N appears on data_o with v_o=1 in cycle N+1.
//  - No bypass: count==0 with v_i=1 gives v_o=0 in the same cycle.
//  - FIFO order is preserved. Head/tail are 1-bit pointers that wrap 1->0.
//  - Simultaneous accept+yumi:
//    - count==1: count stays 1, the new entry becomes head next cycle.
//    - count==2: accept is impossible because ready_o=0; yumi alone drops count to 1.
//  - yumi_i with v_o=0 is illegal. The block ignores it and count does not underflow.
//  - Out-of-range sel_i (sel_i >= els_p, possible when els_p is not a power of 2):
//    the stored element is all zeros.
//  - els_p==1: sel_i is ignored and element 0 is always stored.
//  - Reset is async and has priority at any time, including mid-transfer:
//    - count=0, pointers=0, v_o=0, ready_o=0 while reset_i=1.
//    - ready_o=1 on the first clock edge after reset_i deasserts.
//    - Storage clears to 0, so data_o=0. err_o=0. Buffered entries are discarded.
// CONFIGURATION
//  - Macro BSG_MUX_BUFFERED_SEL_CHECK_EN.
//  - Defined: err_o sets on any accept with sel_i >= els_p. It stays set until reset.
//    Data still stores zeros and the handshake is unaffected.
//  - Not defined: err_o is tied to 0 and no check logic is generated.
//  - Zero-fill for out-of-range sel_i applies in both builds.
// TESTING
//  - Reset/idle: width_p=8, els_p=4. Assert reset_i mid-cycle -> v_o=0, ready_o=0,
//    data_o=0 immediately. After release -> ready_o=1 on the next edge.
//  - Select sweep: data_i={8'h44,8'h33,8'h22,8'h11}, sel_i=0..3 on consecutive
//    cycles, yumi_i tied to v_o -> data_o=11,22,33,44 in cycles 1..4.
//  - Backpressure: 3 accepts (A,B,C) offered with yumi_i=0 -> A,B accepted,
//    ready_o=0, C held. Pulse yumi_i -> A out, C accepted next cycle, order A,B,C.
//  - Simultaneous: count=1 holding X, accept Y with yumi_i=1 -> next cycle
//    count=1, data_o=Y, no cycle with v_o=0.
//  - Select error: els_p=3, sel_i=3 with v_i=1 -> stored data=0.
//    With the macro, err_o=1 from the next cycle until reset. Without it, err_o=0.
//  - Reset mid-transfer: count=2, assert reset_i -> v_o drops asynchronously.
//    After release, the first accepted item is the first item out.

Source files
------------

// File: rtl/bsg_mux_buffered.sv
// Select one of els_p elements and queue it in a 2-entry registered output buffer.
// Optional select-range checking on err_o is enabled by defining BSG_MUX_BUFFERED_SEL_CHECK_EN.
module bsg_mux_buffered #(
  parameter  int width_p   = 128,
  parameter  int els_p     = 2,
  localparam int lg_els_lp = (els_p == 1) ? 1 : $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic [els_p*width_p-1:0] data_i,
  input  logic [lg_els_lp-1:0]     sel_i,
  output logic                     ready_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,
  output logic                     err_o
);

  logic [1:0][width_p-1:0] mem;
  logic                    head, tail;
  logic [1:0]              count, count_n;
  logic                    ready_r;
  logic                    acc, deq;
  logic [lg_els_lp-1:0]    sel_eff;
  logic [width_p-1:0]      sel_data;

  // A single element has nothing to choose from, so the select input is ignored.
  assign sel_eff = (els_p == 1) ? '0 : sel_i;

  // Unmatched (out-of-range) selects fall through to zero.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < els_p; k++)
      if (sel_eff == lg_els_lp'(k)) sel_data = data_i[k*width_p +: width_p];
  end

  assign acc     = v_i & ready_r;
  assign deq     = yumi_i & (count != 2'd0);
  assign count_n = count + 2'(acc) - 2'(deq);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem     <= '0;
      head    <= 1'b0;
      tail    <= 1'b0;
      count   <= 2'd0;
      ready_r <= 1'b0;
    end else begin
      if (acc) begin
        mem[tail] <= sel_data;
        tail      <= ~tail;
      end
      if (deq) head <= ~head;
      count   <= count_n;
      // Held low through reset, then tracks space left in the buffer.
      ready_r <= (count_n != 2'd2);
    end
  end

  assign ready_o = ready_r;
  assign v_o     = (count != 2'd0);
  assign data_o  = mem[head];

`ifdef BSG_MUX_BUFFERED_SEL_CHECK_EN
  logic sel_oob, err_r;

  always_comb begin
    sel_oob = 1'b1;
    for (int k = 0; k < els_p; k++)
      if (sel_eff == lg_els_lp'(k)) sel_oob = 1'b0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)            err_r <= 1'b0;
    else if (acc & sel_oob) err_r <= 1'b1;
  end

  assign err_o = err_r;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_mux_buffered.sv
// Directed bench for bsg_mux_buffered: a 4-element instance driven through a
// scoreboard, plus a 3-element instance for out-of-range select behaviour.
module tb_bsg_mux_buffered;

`ifdef BSG_MUX_BUFFERED_SEL_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        clk, rst;
  logic        a_v, a_ready, a_vo, a_yumi, a_err;
  logic [31:0] a_din;
  logic [1:0]  a_sel;
  logic [7:0]  a_dout;
  logic        b_v, b_ready, b_vo, b_yumi, b_err;
  logic [23:0] b_din;
  logic [1:0]  b_sel;
  logic [7:0]  b_dout;

  int total = 0;
  int fails = 0;
  logic [7:0] sb[$];

  bsg_mux_buffered #(.width_p(8), .els_p(4)) dut_a (
    .clk_i(clk), .reset_i(rst), .v_i(a_v), .data_i(a_din), .sel_i(a_sel),
    .ready_o(a_ready), .v_o(a_vo), .data_o(a_dout), .yumi_i(a_yumi), .err_o(a_err));

  bsg_mux_buffered #(.width_p(8), .els_p(3)) dut_b (
    .clk_i(clk), .reset_i(rst), .v_i(b_v), .data_i(b_din), .sel_i(b_sel),
    .ready_o(b_ready), .v_o(b_vo), .data_o(b_dout), .yumi_i(b_yumi), .err_o(b_err));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus on instance A; entered and left at posedge+1.
  task automatic cyc(input logic v, input logic [1:0] sel, input logic y);
    logic rdy;
    logic [7:0] e;
    a_v = v; a_sel = sel; a_yumi = y;
    #1;
    rdy = (sb.size() < 2);
    chk("a_v_o", a_vo, sb.size() != 0);
    chk("a_ready_o", a_ready, rdy);
    if (y && sb.size() != 0) begin
      e = sb.pop_front();
      chk("a_data_o", a_dout, e);
    end
    if (v && rdy) sb.push_back(a_din[sel*8 +: 8]);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    a_v = 0; a_din = '0; a_sel = 0; a_yumi = 0;
    b_v = 0; b_din = '0; b_sel = 0; b_yumi = 0;

    // reset / idle
    #23;
    chk("rst_v_o", a_vo, 0);
    chk("rst_ready_o", a_ready, 0);
    chk("rst_data_o", a_dout, 0);
    chk("rst_err_o", b_err, 0);
    #3 rst = 1'b0;
    #1 chk("rel_ready_before_edge", a_ready, 0);
    @(posedge clk); #1;
    chk("rel_ready_after_edge", a_ready, 1);
    chk("rel_v_o", a_vo, 0);

    // select sweep, yumi follows v_o
    a_din = 32'h44332211;
    for (int s = 0; s < 4; s++) cyc(1'b1, 2'(s), a_vo);
    cyc(1'b0, 2'd0, a_vo);
    cyc(1'b0, 2'd0, a_vo);

    // backpressure: A,B accepted, C held until space frees
    a_din = 32'hCCBBAA00;
    cyc(1'b1, 2'd1, 1'b0);
    cyc(1'b1, 2'd2, 1'b0);
    cyc(1'b1, 2'd3, 1'b0);
    cyc(1'b1, 2'd3, 1'b1);
    cyc(1'b1, 2'd3, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, a_vo);

    // simultaneous accept + yumi at count 1
    a_din = 32'h00007E5A;
    cyc(1'b1, 2'd0, 1'b0);
    cyc(1'b1, 2'd1, 1'b1);
    cyc(1'b0, 2'd0, a_vo);
    cyc(1'b0, 2'd0, 1'b0);

    // yumi while empty is ignored
    cyc(1'b0, 2'd0, 1'b1);
    cyc(1'b0, 2'd0, 1'b0);

    // out-of-range select on the 3-element instance
    b_din = 24'h332211;
    b_v = 1; b_sel = 2'd3;
    #1 chk("b_err_before", b_err, 0);
    @(posedge clk); #1;
    b_v = 0;
    chk("b_oob_v_o", b_vo, 1);
    chk("b_oob_data", b_dout, 0);
    chk("b_err_set", b_err, ERR_EXP);
    b_yumi = 1;
    @(posedge clk); #1;
    b_yumi = 0;
    chk("b_v_o_drained", b_vo, 0);
    b_v = 1; b_sel = 2'd2;
    @(posedge clk); #1;
    b_v = 0;
    chk("b_inrange_data", b_dout, 8'h33);
    b_yumi = 1;
    @(posedge clk); #1;
    b_yumi = 0;
    chk("b_err_sticky", b_err, ERR_EXP);

    // reset mid-transfer with two entries buffered
    a_din = 32'h44332211;
    cyc(1'b1, 2'd0, 1'b0);
    cyc(1'b1, 2'd1, 1'b0);
    a_v = 0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_v_o", a_vo, 0);
    chk("mid_rst_ready_o", a_ready, 0);
    chk("mid_rst_data_o", a_dout, 0);
    chk("mid_rst_err_o", b_err, 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rel_ready", a_ready, 1);
    cyc(1'b1, 2'd3, 1'b0);
    cyc(1'b0, 2'd0, a_vo);
    cyc(1'b0, 2'd0, 1'b0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
